// File: rtl/modulo_controle_rolhas_caixa_pkg.sv
// Purpose: shared constants and box FSM encoding for the cork/box controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package modulo_controle_rolhas_caixa_pkg;

    localparam int MAX_ROLHAS     = 99;
    localparam int LOTE_RECARGA   = 15;
    localparam int GARRAFAS_CAIXA = 12;
    localparam int LIMIAR_BAIXO   = 5;

    localparam int W_RO = 7;
    localparam int W_GF = 4;

    typedef enum logic [0:0] {
        CONTANDO    = 1'b0,
        CAIXA_CHEIA = 1'b1
    } estado_t;

endpackage

// File: rtl/modulo_detector_borda.sv
// Purpose: rising-edge detector for an operator/FSM level, one event per 0->1.
// Latency: input sampled high at edge k gives pulso high for the cycle after edge k.
// Backpressure: none; history always tracks the input, events are single-cycle.
module modulo_detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulso
);

    logic hist;
    // Set once a low level has been seen after reset, so a level already
    // high when reset releases cannot fake an edge.
    logic armado;

    // History, arming and registered pulse; runs every cycle independent of enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist   <= 1'b0;
            armado <= 1'b0;
            pulso  <= 1'b0;
        end else begin
            hist   <= d;
            armado <= armado | ~d;
            pulso  <= d & ~hist & armado;
        end
    end

endmodule

// File: rtl/modulo_controle_rolhas_caixa.sv
// Purpose: cork stock and bottles-per-box counter with box-full FSM and low-stock alarm.
// Latency: input 0->1 sampled at edge k updates counts/outputs at edge k+1.
// Backpressure: eb holds the sealing FSM while the box is full; ro=0 blocks sealing.
module modulo_controle_rolhas_caixa
    import modulo_controle_rolhas_caixa_pkg::*;
#(
    parameter int MAX_ROLHAS     = modulo_controle_rolhas_caixa_pkg::MAX_ROLHAS,
    parameter int LOTE_RECARGA   = modulo_controle_rolhas_caixa_pkg::LOTE_RECARGA,
    parameter int GARRAFAS_CAIXA = modulo_controle_rolhas_caixa_pkg::GARRAFAS_CAIXA,
    parameter int LIMIAR_BAIXO   = modulo_controle_rolhas_caixa_pkg::LIMIAR_BAIXO
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            ve,
    input  logic            add_ro,
    input  logic            ack_cx,
    output logic            ro,
    output logic            eb,
    output logic            al_ro,
    output logic [W_RO-1:0] cnt_ro,
    output logic [W_GF-1:0] cnt_gf
);

    logic    pulso_ve;
    logic    pulso_add;
    logic    pulso_ack;
    estado_t estado;
    estado_t estado_prox;
    logic    ve_aceito;
    logic    add_aceito;
    logic    ack_aceito;
    logic    caixa_completa;
    logic [W_RO:0]   soma_ro;
    logic [W_RO-1:0] cnt_ro_prox;
    logic [W_GF-1:0] cnt_gf_prox;

    modulo_detector_borda u_borda_ve (
        .clk   (clk),
        .rst   (rst),
        .d     (ve),
        .pulso (pulso_ve)
    );

    modulo_detector_borda u_borda_add (
        .clk   (clk),
        .rst   (rst),
        .d     (add_ro),
        .pulso (pulso_add)
    );

    modulo_detector_borda u_borda_ack (
        .clk   (clk),
        .rst   (rst),
        .d     (ack_cx),
        .pulso (pulso_ack)
    );

    // Qualify events: enable gates all of them; a seal needs a cork and an open box.
    always_comb begin
        ve_aceito      = enable & pulso_ve & (estado == CONTANDO) & (cnt_ro != '0);
        add_aceito     = enable & pulso_add;
        ack_aceito     = enable & pulso_ack & (estado == CAIXA_CHEIA);
        caixa_completa = (cnt_gf == W_GF'(GARRAFAS_CAIXA - 1));
    end

    // Box FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado <= CONTANDO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Box FSM next state: fills on the last accepted seal, empties on acknowledge.
    always_comb begin
        estado_prox = estado;
        case (estado)
            CONTANDO: begin
                if (ve_aceito && caixa_completa) begin
                    estado_prox = CAIXA_CHEIA;
                end
            end
            CAIXA_CHEIA: begin
                if (ack_aceito) begin
                    estado_prox = CONTANDO;
                end
            end
            default: estado_prox = CONTANDO;
        endcase
    end

    // Box FSM output decode.
    always_comb begin
        eb = (estado == CAIXA_CHEIA);
    end

    // Next counter values: seal takes one cork, refill adds a batch clipped at the maximum.
    always_comb begin
        soma_ro = {1'b0, cnt_ro} - {{W_RO{1'b0}}, ve_aceito};
        if (add_aceito) begin
            soma_ro = soma_ro + (W_RO + 1)'(LOTE_RECARGA);
            if (soma_ro > (W_RO + 1)'(MAX_ROLHAS)) begin
                soma_ro = (W_RO + 1)'(MAX_ROLHAS);
            end
        end
        cnt_ro_prox = soma_ro[W_RO-1:0];

        cnt_gf_prox = cnt_gf;
        if (ack_aceito) begin
            cnt_gf_prox = '0;
        end else if (ve_aceito) begin
            cnt_gf_prox = cnt_gf + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_ro <= '0;
            cnt_gf <= '0;
        end else begin
            cnt_ro <= cnt_ro_prox;
            cnt_gf <= cnt_gf_prox;
        end
    end

    // Status decodes fed back to the sealing FSM and operator panel.
    always_comb begin
        ro    = (cnt_ro != '0);
        al_ro = (cnt_ro < W_RO'(LIMIAR_BAIXO));
    end

endmodule

// File: tb/tb_modulo_controle_rolhas_caixa.sv
module tb_modulo_controle_rolhas_caixa;
    import modulo_controle_rolhas_caixa_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ve;
    logic       add_ro;
    logic       ack_cx;
    logic       ro;
    logic       eb;
    logic       al_ro;
    logic [6:0] cnt_ro;
    logic [3:0] cnt_gf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    modulo_controle_rolhas_caixa dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .ve     (ve),
        .add_ro (add_ro),
        .ack_cx (ack_cx),
        .ro     (ro),
        .eb     (eb),
        .al_ro  (al_ro),
        .cnt_ro (cnt_ro),
        .cnt_gf (cnt_gf)
    );

    // Behavioural model: stock, bottles in box, box-full flag, plus events
    // waiting one cycle before they take effect.
    int m_ro;
    int m_gf;
    bit m_full;
    bit m_valid = 1'b0;
    bit ev_ve, ev_add, ev_ack;
    bit last_ve, last_add, last_ack;
    bit low_ve, low_add, low_ack;

    always @(posedge clk) begin
        if (!rst) begin
            m_ro = 0; m_gf = 0; m_full = 1'b0;
            ev_ve = 0; ev_add = 0; ev_ack = 0;
            last_ve = 0; last_add = 0; last_ack = 0;
            low_ve = 0; low_add = 0; low_ack = 0;
            m_valid = 1'b1;
        end else begin
            if (enable) begin
                bit seal_ok;
                int novo;
                seal_ok = ev_ve && !m_full && (m_ro > 0);
                if (ev_ack && m_full) begin
                    m_gf = 0;
                    m_full = 1'b0;
                end else if (seal_ok) begin
                    m_gf = m_gf + 1;
                    if (m_gf == GARRAFAS_CAIXA) m_full = 1'b1;
                end
                novo = m_ro - (seal_ok ? 1 : 0);
                if (ev_add) novo = (novo + LOTE_RECARGA > MAX_ROLHAS) ? MAX_ROLHAS : novo + LOTE_RECARGA;
                m_ro = novo;
            end
            // A new event needs a 0->1 seen after the input was low since reset.
            ev_ve  = ve     && !last_ve  && low_ve;
            ev_add = add_ro && !last_add && low_add;
            ev_ack = ack_cx && !last_ack && low_ack;
            last_ve = ve; last_add = add_ro; last_ack = ack_cx;
            low_ve  = low_ve  || !ve;
            low_add = low_add || !add_ro;
            low_ack = low_ack || !ack_cx;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (cnt_ro !== 7'(m_ro) || cnt_gf !== 4'(m_gf) || ro !== (m_ro != 0)
                || eb !== m_full || al_ro !== (m_ro < LIMIAR_BAIXO)) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t: got cnt_ro=%0d cnt_gf=%0d ro=%b eb=%b al_ro=%b, need cnt_ro=%0d cnt_gf=%0d ro=%b eb=%b al_ro=%b",
                         $time, cnt_ro, cnt_gf, ro, eb, al_ro, m_ro, m_gf, (m_ro != 0), m_full, (m_ro < LIMIAR_BAIXO));
            end
        end
    end

    task automatic chk(input string nome, input int atual, input int esperado);
        n_checks++;
        if (atual != esperado) begin
            n_errors++;
            $display("FAIL %s: got %0d, need %0d", nome, atual, esperado);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle high pulse on the selected inputs, then time for it to take effect.
    task automatic pulsa(input bit pv, input bit pa, input bit pk);
        ve = pv; add_ro = pa; ack_cx = pk;
        tick(1);
        ve = 1'b0; add_ro = 1'b0; ack_cx = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; ve = 1'b0; add_ro = 1'b0; ack_cx = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("reset_cnt_ro", cnt_ro, 0);
        chk("reset_cnt_gf", cnt_gf, 0);
        chk("reset_ro", ro, 0);
        chk("reset_eb", eb, 0);
        chk("reset_al_ro", al_ro, 1);

        // Refill and saturation
        repeat (3) pulsa(0, 1, 0);
        chk("refill3_cnt_ro", cnt_ro, 45);
        chk("refill3_model", m_ro, 45);
        chk("refill3_ro", ro, 1);
        chk("refill3_al_ro", al_ro, 0);
        repeat (4) pulsa(0, 1, 0);
        chk("refill_sat_cnt_ro", cnt_ro, 99);

        // Seal with empty stock, then held level counts once
        do_reset();
        pulsa(1, 0, 0);
        chk("empty_seal_cnt_ro", cnt_ro, 0);
        chk("empty_seal_cnt_gf", cnt_gf, 0);
        chk("empty_seal_ro", ro, 0);
        repeat (2) pulsa(0, 1, 0);
        repeat (10) pulsa(1, 0, 0);
        chk("stock20_cnt_ro", cnt_ro, 20);
        ve = 1'b1;
        tick(10);
        ve = 1'b0;
        tick(2);
        chk("held_ve_cnt_ro", cnt_ro, 19);
        chk("held_ve_cnt_gf", cnt_gf, 11);

        // Box fill, ignore when full, acknowledge
        do_reset();
        repeat (2) pulsa(0, 1, 0);
        repeat (12) pulsa(1, 0, 0);
        chk("full_cnt_gf", cnt_gf, 12);
        chk("full_eb", eb, 1);
        chk("full_cnt_ro", cnt_ro, 18);
        chk("full_model_gf", m_gf, 12);
        pulsa(1, 0, 0);
        chk("full_13th_cnt_ro", cnt_ro, 18);
        chk("full_13th_cnt_gf", cnt_gf, 12);
        pulsa(0, 0, 1);
        chk("ack_cnt_gf", cnt_gf, 0);
        chk("ack_eb", eb, 0);
        chk("ack_cnt_ro", cnt_ro, 18);

        // Simultaneous refill and seal
        repeat (8) pulsa(1, 0, 0);
        chk("pre_sim_cnt_ro", cnt_ro, 10);
        pulsa(1, 1, 0);
        chk("sim_cnt_ro", cnt_ro, 24);
        chk("sim_cnt_gf", cnt_gf, 9);
        do_reset();
        repeat (6) pulsa(0, 1, 0);
        chk("stock90_cnt_ro", cnt_ro, 90);
        pulsa(1, 1, 0);
        chk("sim_sat_cnt_ro", cnt_ro, 99);
        chk("sim_sat_cnt_gf", cnt_gf, 1);

        // Disabled events are lost; re-enable with level held makes no event
        enable = 1'b0;
        pulsa(1, 1, 0);
        chk("dis_cnt_ro", cnt_ro, 99);
        chk("dis_cnt_gf", cnt_gf, 1);
        ve = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(3);
        chk("reen_cnt_ro", cnt_ro, 99);
        chk("reen_cnt_gf", cnt_gf, 1);
        ve = 1'b0;
        tick(2);

        // Reset while the box is full
        do_reset();
        repeat (4) pulsa(0, 1, 0);
        repeat (12) pulsa(1, 0, 0);
        chk("pre_rst_eb", eb, 1);
        chk("pre_rst_cnt_ro", cnt_ro, 48);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("midrst_cnt_ro", cnt_ro, 0);
        chk("midrst_cnt_gf", cnt_gf, 0);
        chk("midrst_eb", eb, 0);
        chk("midrst_al_ro", al_ro, 1);
        tick(1);

        // Level held across reset release does not count
        add_ro = 1'b1;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(4);
        chk("held_rst_cnt_ro", cnt_ro, 0);
        add_ro = 1'b0;
        tick(2);
        pulsa(0, 1, 0);
        chk("after_held_cnt_ro", cnt_ro, 15);

        // Randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 3) == 0)  ve = ~ve;
            if ($urandom_range(0, 5) == 0)  ack_cx = ~ack_cx;
            if ($urandom_range(0, 11) == 0) add_ro = ~add_ro;
        end
        rst = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
